// File: rtl/tagger_filter_config.sv
// Tagger filter configuration block.
// Host writes land in a shadow copy. A commit request waits for the
// tagger channels to go quiet, with a timeout fallback, and then loads
// every deadtime, the channel mask and the laser enable in one edge.
module tagger_filter_config #(
  parameter int CHANNELS = 8,
  parameter int QUIET    = 4,
  parameter int TIMEOUT  = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [3:0]               wr_addr,
  input  logic [15:0]              wr_data,
  input  logic                     commit_req,
  input  logic [CHANNELS-1:0]      activity,
  output logic [CHANNELS*16-1:0]   deadtimes,
  output logic [CHANNELS-1:0]      enable_channel,
  output logic                     enable_laser_filter,
  output logic                     commit_busy,
  output logic                     commit_done,
  output logic                     commit_forced,
  output logic                     staged_dirty
);

  localparam int            CW         = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] QUIET_LAST = CW'(QUIET - 1);
  localparam logic [CW-1:0] TMO_LAST   = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};
  localparam logic [3:0]    MASK_ADDR  = 4'(CHANNELS);
  localparam logic [3:0]    LASER_ADDR = 4'(CHANNELS + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_QUIET,
    ST_COMMIT
  } state_t;

  state_t state;
  state_t next_state;

  logic [CHANNELS-1:0][15:0] shadow_dt;
  logic [CHANNELS-1:0][15:0] active_dt;
  logic [CHANNELS-1:0]       shadow_mask;
  logic [CHANNELS-1:0]       active_mask;
  logic                      shadow_laser;
  logic                      active_laser;

  logic [CW-1:0] quiet_cnt;
  logic [CW-1:0] tmo_cnt;
  logic          forced_flag;
  logic          go_forced;
  logic          wr_fire;
  logic          wr_stages;

  assign deadtimes           = active_dt;
  assign enable_channel      = active_mask;
  assign enable_laser_filter = active_laser;

  // State register for the commit sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic, write handshake, and detection of a timeout-forced commit.
  always_comb begin
    next_state  = state;
    go_forced   = 1'b0;
    wr_ready    = (state == ST_IDLE);
    commit_busy = (state != ST_IDLE);
    wr_fire     = wr_valid && (state == ST_IDLE);
    wr_stages   = wr_fire && (wr_addr <= LASER_ADDR);
    case (state)
      ST_IDLE: begin
        if (commit_req) begin
          // Something staged (now or in this same cycle) must wait for quiet;
          // an empty commit simply re-applies the shadow right away.
          if (staged_dirty || wr_stages) begin
            next_state = ST_QUIET;
          end else begin
            next_state = ST_COMMIT;
          end
        end
      end
      ST_QUIET: begin
        // The quiet condition takes priority when both conditions land together.
        if ((activity == '0) && (quiet_cnt == QUIET_LAST)) begin
          next_state = ST_COMMIT;
        end else if (tmo_cnt == TMO_LAST) begin
          next_state = ST_COMMIT;
          go_forced  = 1'b1;
        end
      end
      ST_COMMIT: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Quiet and timeout counters: they run only in QUIET and saturate instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quiet_cnt <= '0;
      tmo_cnt   <= '0;
    end else if (state == ST_QUIET) begin
      if (tmo_cnt != CNT_MAX) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (activity != '0) begin
        quiet_cnt <= '0;
      end else if (quiet_cnt != CNT_MAX) begin
        quiet_cnt <= quiet_cnt + 1'b1;
      end
    end else begin
      quiet_cnt <= '0;
      tmo_cnt   <= '0;
    end
  end

  // Remember why we entered COMMIT, then emit the registered done and forced pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      forced_flag   <= 1'b0;
      commit_done   <= 1'b0;
      commit_forced <= 1'b0;
    end else begin
      commit_done   <= (state == ST_COMMIT);
      commit_forced <= (state == ST_COMMIT) && forced_flag;
      if (go_forced) begin
        forced_flag <= 1'b1;
      end else if (state == ST_COMMIT) begin
        forced_flag <= 1'b0;
      end
    end
  end

  // Shadow writes, the dirty flag, and the single-edge shadow-to-active load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_dt    <= '0;
      shadow_mask  <= '0;
      shadow_laser <= 1'b0;
      active_dt    <= '0;
      active_mask  <= '0;
      active_laser <= 1'b0;
      staged_dirty <= 1'b0;
    end else begin
      if (wr_fire) begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (wr_addr == 4'(i)) begin
            shadow_dt[i] <= wr_data;
          end
        end
        if (wr_addr == MASK_ADDR) begin
          shadow_mask <= wr_data[CHANNELS-1:0];
        end
        if (wr_addr == LASER_ADDR) begin
          shadow_laser <= wr_data[0];
        end
      end
      if (wr_stages) begin
        staged_dirty <= 1'b1;
      end
      if (state == ST_COMMIT) begin
        active_dt    <= shadow_dt;
        active_mask  <= shadow_mask;
        active_laser <= shadow_laser;
        staged_dirty <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tagger_filter_config.sv
// Scoreboard bench for tagger_filter_config: stimulus queues the expected
// commit result, a monitor checks it whenever commit_done fires.
module tb_tagger_filter_config;

  localparam int CHANNELS = 8;
  localparam int QUIET    = 4;
  localparam int TIMEOUT  = 16;

  logic                   clk;
  logic                   rst_n;
  logic                   wr_valid;
  logic                   wr_ready;
  logic [3:0]             wr_addr;
  logic [15:0]            wr_data;
  logic                   commit_req;
  logic [CHANNELS-1:0]    activity;
  logic [CHANNELS*16-1:0] deadtimes;
  logic [CHANNELS-1:0]    enable_channel;
  logic                   enable_laser_filter;
  logic                   commit_busy;
  logic                   commit_done;
  logic                   commit_forced;
  logic                   staged_dirty;

  typedef struct {
    int           cyc;
    logic         forced;
    logic [127:0] dt;
    logic [7:0]   mask;
    logic         laser;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  logic [7:0][15:0] sh_dt;
  logic [7:0]       sh_mask;
  logic             sh_laser;

  int cyc;
  int checks;
  int errors;
  int n;

  tagger_filter_config #(
    .CHANNELS(CHANNELS),
    .QUIET(QUIET),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .commit_req(commit_req),
    .activity(activity),
    .deadtimes(deadtimes),
    .enable_channel(enable_channel),
    .enable_laser_filter(enable_laser_filter),
    .commit_busy(commit_busy),
    .commit_done(commit_done),
    .commit_forced(commit_forced),
    .staged_dirty(staged_dirty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index: number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle from a negedge; n returns the cycle index the edge samples.
  task automatic applyStimulus(input logic do_wr, input logic [3:0] addr, input logic [15:0] data,
                               input logic do_commit, output int n_out);
    n_out      = cyc;
    wr_valid   = do_wr;
    wr_addr    = addr;
    wr_data    = data;
    commit_req = do_commit;
    if (do_wr) begin
      if (addr < 4'd8) sh_dt[addr[2:0]] = data;
      else if (addr == 4'd8) sh_mask = data[7:0];
      else if (addr == 4'd9) sh_laser = data[0];
    end
    @(negedge clk);
    wr_valid   = 1'b0;
    commit_req = 1'b0;
  endtask

  task automatic pushExpect(input int at, input logic forced);
    exp_q.push_back('{at, forced, sh_dt, sh_mask, sh_laser});
  endtask

  task automatic waitDone();
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) @(negedge clk);
    checkOutput("pending_done", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Monitor: every commit_done must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && commit_done) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_done", commit_done, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("done_cycle", cyc, mon_e.cyc);
        checkOutput("done_forced", commit_forced, mon_e.forced);
        checkOutput("done_deadtimes", deadtimes, mon_e.dt);
        checkOutput("done_mask", enable_channel, mon_e.mask);
        checkOutput("done_laser", enable_laser_filter, mon_e.laser);
      end
    end else if (commit_forced) begin
      checkOutput("stray_forced", commit_forced, 1'b0);
    end
  end

  initial begin
    cyc = 0; checks = 0; errors = 0;
    sh_dt = '0; sh_mask = '0; sh_laser = 1'b0;
    rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    commit_req = 1'b0; activity = '0;

    // Reset state.
    #1;
    checkOutput("rst_deadtimes", deadtimes, 0);
    checkOutput("rst_mask", enable_channel, 0);
    checkOutput("rst_done", commit_done, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_wr_ready", wr_ready, 1);
    checkOutput("idle_busy", commit_busy, 0);
    checkOutput("idle_dirty", staged_dirty, 0);

    // Quiet-path commit: done QUIET+2 cycles after the request.
    $display("[TB] quiet commit");
    applyStimulus(1'b1, 4'd2, 16'h0040, 1'b0, n);
    applyStimulus(1'b1, 4'd8, 16'h00FF, 1'b0, n);
    checkOutput("dirty_after_write", staged_dirty, 1);
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1, n);
    pushExpect(n + QUIET + 2, 1'b0);
    checkOutput("quiet_wr_ready", wr_ready, 0);
    checkOutput("quiet_busy", commit_busy, 1);
    checkOutput("quiet_active_unchanged", deadtimes, 0);
    waitDone();
    checkOutput("ch2_deadtime", deadtimes[47:32], 16'h0040);
    checkOutput("mask_ff", enable_channel, 8'hFF);
    checkOutput("dirty_cleared", staged_dirty, 0);

    // Activity in the third QUIET cycle restarts the quiet count.
    $display("[TB] activity delays commit");
    applyStimulus(1'b1, 4'd5, 16'h1234, 1'b0, n);
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1, n);
    pushExpect(n + QUIET + 5, 1'b0);
    repeat (2) @(negedge clk);
    activity = 8'h01;
    @(negedge clk);
    activity = 8'h00;
    repeat (2) @(negedge clk);
    checkOutput("ch5_not_yet", deadtimes[95:80], 16'h0000);
    waitDone();

    // Write and second request during QUIET are ignored.
    $display("[TB] busy write ignored");
    applyStimulus(1'b1, 4'd9, 16'h0001, 1'b0, n);
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1, n);
    pushExpect(n + QUIET + 2, 1'b0);
    wr_valid = 1'b1; wr_addr = 4'd0; wr_data = 16'hBEEF; commit_req = 1'b1;
    #1;
    checkOutput("busy_wr_ready", wr_ready, 0);
    @(negedge clk);
    wr_valid = 1'b0; commit_req = 1'b0;
    waitDone();
    repeat (8) @(negedge clk);
    checkOutput("ch0_untouched", deadtimes[15:0], 16'h0000);
    checkOutput("laser_on", enable_laser_filter, 1);

    // Timeout: activity every third cycle never allows QUIET idle cycles.
    // QUIET lasts TIMEOUT cycles, then one COMMIT cycle, then done.
    $display("[TB] forced commit");
    applyStimulus(1'b1, 4'd3, 16'h0077, 1'b0, n);
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1, n);
    pushExpect(n + TIMEOUT + 2, 1'b1);
    for (int i = 1; i <= TIMEOUT + 1; i++) begin
      activity = (i % 3 == 1) ? 8'h08 : 8'h00;
      @(negedge clk);
    end
    activity = 8'h00;
    waitDone();
    checkOutput("ch3_deadtime", deadtimes[63:48], 16'h0077);

    // Out-of-range write is dropped, so the commit goes straight through.
    $display("[TB] invalid address");
    applyStimulus(1'b1, 4'd15, 16'hFFFF, 1'b0, n);
    checkOutput("invalid_no_dirty", staged_dirty, 0);
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1, n);
    pushExpect(n + 2, 1'b0);
    checkOutput("direct_commit_busy", commit_busy, 1);
    waitDone();

    // Write in the same cycle as the request is part of that commit.
    $display("[TB] same-cycle write and commit");
    applyStimulus(1'b1, 4'd1, 16'h0AAA, 1'b1, n);
    pushExpect(n + QUIET + 2, 1'b0);
    waitDone();
    checkOutput("ch1_deadtime", deadtimes[31:16], 16'h0AAA);

    // Reset in QUIET discards the pending commit.
    $display("[TB] reset mid-quiet");
    applyStimulus(1'b1, 4'd4, 16'h5555, 1'b0, n);
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1, n);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_deadtimes", deadtimes, 0);
    checkOutput("async_rst_mask", enable_channel, 0);
    checkOutput("async_rst_laser", enable_laser_filter, 0);
    checkOutput("async_rst_busy", commit_busy, 0);
    sh_dt = '0; sh_mask = '0; sh_laser = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("post_rst_busy", commit_busy, 0);
    checkOutput("post_rst_dirty", staged_dirty, 0);
    checkOutput("post_rst_deadtimes", deadtimes, 0);
    checkOutput("post_rst_queue", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
